// File: rtl/jt12_pg_ring_pkg.sv
// Shared phase-generator dimensions: slot count, phase and operator widths.
// Also used by the comb, envelope and operator stages.
package jt12_pg_ring_pkg;

    localparam int unsigned PG_SLOTS = 24;
    localparam int unsigned PG_PW    = 20;
    localparam int unsigned PG_OPW   = 10;
    localparam int unsigned SLOT_W   = 5;

    // Slot index successor, wrapping from n-1 back to 0 in a single step.
    function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] s,
                                                    input int unsigned        n);
        if (s == SLOT_W'(n - 1))
            return '0;
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/jt12_sh_ring.sv
// Generic W-bit, N-deep shift ring with step enable and synchronous reset.
// The head takes i_din on each enabled step; o_dout is the tail entry.
module jt12_sh_ring #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout
);

    logic [W-1:0] r_ring [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N; k++)
                r_ring[k] <= '0;
        end else if (i_en) begin
            r_ring[0] <= i_din;
            for (int unsigned k = 1; k < N; k++)
                r_ring[k] <= r_ring[k-1];
        end
    end

    assign o_dout = r_ring[N-1];

endmodule

// File: rtl/jt12_pg_ring.sv
// Per-slot phase storage and sequencing for the FM phase generator: phase
// ring, key-on ring, slot counter, phase-reset pulse and operator phase.
module jt12_pg_ring
    import jt12_pg_ring_pkg::*;
#(
    parameter int unsigned SLOTS = PG_SLOTS,
    parameter int unsigned PW    = PG_PW,
    parameter int unsigned OPW   = PG_OPW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              keyon,
    input  logic [PW-1:0]     phase_nx,
    output logic [PW-1:0]     phase_cur,
    output logic              pg_rst,
    output logic [OPW-1:0]    phase_op,
    output logic [SLOT_W-1:0] slot,
    output logic              zero
);

    logic [SLOT_W-1:0] r_slot;
    logic [OPW-1:0]    r_phase_op;
    logic              w_kon_prev;

    // N-deep ring: the tail during a slot is what that slot wrote one round ago.
    jt12_sh_ring #(
        .W (PW),
        .N (SLOTS)
    ) u_phase_ring (
        .clk    (clk),
        .rst    (rst),
        .i_en   (clk_en),
        .i_din  (phase_nx),
        .o_dout (phase_cur)
    );

    jt12_sh_ring #(
        .W (1),
        .N (SLOTS)
    ) u_kon_ring (
        .clk    (clk),
        .rst    (rst),
        .i_en   (clk_en),
        .i_din  (keyon),
        .o_dout (w_kon_prev)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot     <= '0;
            r_phase_op <= '0;
        end else if (clk_en) begin
            r_slot     <= slot_next(r_slot, SLOTS);
            r_phase_op <= phase_nx[PW-1 -: OPW];
        end
    end

    assign pg_rst   = keyon & ~w_kon_prev;
    assign phase_op = r_phase_op;
    assign slot     = r_slot;
    assign zero     = (r_slot == '0);

endmodule

// File: tb/tb_jt12_pg_ring.sv
// Scoreboard bench for jt12_pg_ring: stimulus pushes expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_jt12_pg_ring;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b0;
    logic        keyon = 1'b0;
    logic [19:0] phase_nx = '0;
    logic [19:0] phase_cur;
    logic        pg_rst;
    logic [9:0]  phase_op;
    logic [4:0]  slot;
    logic        zero;

    jt12_pg_ring #(
        .SLOTS (24),
        .PW    (20),
        .OPW   (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .keyon     (keyon),
        .phase_nx  (phase_nx),
        .phase_cur (phase_cur),
        .pg_rst    (pg_rst),
        .phase_op  (phase_op),
        .slot      (slot),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] cur;
        logic        pg;
        logic [9:0]  op;
        logic [4:0]  slot;
        logic        zero;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;

    // Reference state: one entry per slot, indexed directly by slot number.
    logic [19:0] m_ph  [24];
    logic        m_kon [24];
    logic [9:0]  m_op;
    int          m_slot;

    task automatic check(input string nm, input string fld,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got=%h want=%h at %0t", nm, fld, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.name, "phase_cur", 32'(phase_cur), 32'(e.cur));
            check(e.name, "pg_rst",    32'(pg_rst),    32'(e.pg));
            check(e.name, "phase_op",  32'(phase_op),  32'(e.op));
            check(e.name, "slot",      32'(slot),      32'(e.slot));
            check(e.name, "zero",      32'(zero),      32'(e.zero));
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 24; i++) begin
            m_ph[i]  = '0;
            m_kon[i] = 1'b0;
        end
        m_op   = '0;
        m_slot = 0;
    endtask

    task automatic do_reset(input logic en, input int cycles);
        @(posedge clk); #2;
        rst = 1'b1; clk_en = en; keyon = 1'b0; phase_nx = 20'hABCDE;
        repeat (cycles - 1) @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0; clk_en = 1'b0;
        model_clear();
    endtask

    // One cycle of stimulus; the expectation describes outputs during it.
    task automatic step(input logic en, input logic kon,
                        input logic [19:0] nx, input string nm);
        exp_t e;
        @(posedge clk); #2;
        clk_en = en; keyon = kon; phase_nx = nx;
        e.cur  = m_ph[m_slot];
        e.pg   = kon & ~m_kon[m_slot];
        e.op   = m_op;
        e.slot = 5'(m_slot);
        e.zero = (m_slot == 0);
        e.name = nm;
        q.push_back(e);
        if (en) begin
            m_ph[m_slot]  = nx;
            m_kon[m_slot] = kon;
            m_op          = nx[19:10];
            m_slot        = (m_slot == 23) ? 0 : m_slot + 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        do_reset(1'b0, 2);

        repeat (24) step(1'b1, 1'b0, 20'h0, "reset_round");

        for (int r = 0; r < 10; r++)
            for (int s = 0; s < 24; s++)
                step(1'b1, 1'b0, m_ph[m_slot] + 20'h100, "accum");
        // Round 11: every slot must read 0xA00; phase_op follows 0xA00[19:10].
        repeat (24) step(1'b1, 1'b0, m_ph[m_slot], "accum_r11");

        for (int s = 0; s < 24; s++)
            step(1'b1, 1'b0, (m_slot == 7) ? 20'hFFFF0 : m_ph[m_slot], "wrap_load");
        for (int s = 0; s < 24; s++)
            step(1'b1, 1'b0, (m_ph[m_slot] + 20'h20) & 20'hFFFFF, "wrap_add");
        repeat (24) step(1'b1, 1'b0, m_ph[m_slot], "wrap_read");

        do_reset(1'b0, 2);
        for (int r = 1; r <= 7; r++)
            for (int s = 0; s < 24; s++)
                step(1'b1, (s == 5) && (r >= 2) && (r != 5), m_ph[m_slot] + 20'h40, "keyon");

        repeat (12) step(1'b1, 1'b0, m_ph[m_slot] + 20'h400, "gate_pre");
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 20'(32'h13579 * (i + 1)), "gate_hold");
        repeat (12) step(1'b1, 1'b0, m_ph[m_slot] + 20'h400, "gate_post");

        repeat (13) step(1'b1, 1'b1, m_ph[m_slot] + 20'h777, "midrst_pre");
        do_reset(1'b1, 1);
        repeat (24) step(1'b1, 1'b0, 20'h0, "midrst_post");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
